// File: rtl/spi_oled_rx_if.sv
// spi_oled_rx_if: memory-mapped bus between a CPU master and the SPI receiver.
// master drives valid/wstrb/addr/wdata; slave returns ready pulse and rdata.
interface spi_oled_rx_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  modport master (output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, input iomem_ready, iomem_rdata);
  modport slave  (input iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, output iomem_ready, iomem_rdata);
endinterface

// File: rtl/spi_oled_rx.sv
// spi_oled_rx: SPI target capturing {dc, byte} into a FIFO read over a memory-mapped bus.
// Ports: clk, resetn (sync, active-low), bus (slave modport: 0x00 RXDATA, 0x04 STATUS, 0x08 CTRL),
//        spi_sclk/spi_mosi/spi_cs/spi_dc/spi_res (asynchronous, cs and res active-low).
module spi_oled_rx #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic           clk,
  input  logic           resetn,
  spi_oled_rx_if.slave   bus,
  input  logic           spi_sclk,
  input  logic           spi_mosi,
  input  logic           spi_cs,
  input  logic           spi_dc,
  input  logic           spi_res
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [1:0]    r_sclk_sync, r_mosi_sync, r_cs_sync, r_dc_sync, r_res_sync;
  logic          r_sclk_prev;
  logic [3:0]    r_bitcnt;
  logic [6:0]    r_shift;
  logic [8:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_ovf, r_res_seen, r_ready;
  logic [31:0]   r_rdata;
  logic          w_sclk, w_mosi, w_cs, w_dc, w_res, w_rise, w_byte_done;
  logic          w_start, w_wr, w_empty, w_full, w_pop, w_ctrl, w_flush, w_push, w_ovf_set;
  logic [7:0]    w_addr;
  logic [31:0]   w_status;
  logic          w_unused;
  assign w_sclk      = r_sclk_sync[1];
  assign w_mosi      = r_mosi_sync[1];
  assign w_cs        = r_cs_sync[1];
  assign w_dc        = r_dc_sync[1];
  assign w_res       = r_res_sync[1];
  assign w_rise      = w_sclk & ~r_sclk_prev;
  assign w_byte_done = w_res & ~w_cs & w_rise & (r_bitcnt == 4'd7);
  assign w_start     = bus.iomem_valid & ~r_ready;
  assign w_wr        = |bus.iomem_wstrb;
  assign w_addr      = bus.iomem_addr[7:0];
  assign w_empty     = r_count == '0;
  assign w_full      = r_count == (AW+1)'(FIFO_DEPTH);
  assign w_pop       = w_start & ~w_wr & (w_addr == 8'h00) & ~w_empty;
  assign w_ctrl      = w_start & w_wr & (w_addr == 8'h08);
  assign w_flush     = ~w_res | (w_ctrl & bus.iomem_wdata[1]);
  // a full FIFO still accepts a byte when the same cycle frees a slot
  assign w_push      = w_byte_done & ~w_flush & (~w_full | w_pop);
  assign w_ovf_set   = w_byte_done & ~w_flush & w_full & ~w_pop;
  assign w_status    = {16'b0, r_bitcnt, r_res_seen, r_ovf, w_full, w_empty, 1'b0, 7'(r_count)};
  assign w_unused    = ^{bus.iomem_addr[31:8], bus.iomem_wdata[31:3]};
  assign bus.iomem_ready = r_ready;
  assign bus.iomem_rdata = r_rdata;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sclk_sync <= 2'b00;
      r_mosi_sync <= 2'b00;
      r_cs_sync   <= 2'b11;
      r_dc_sync   <= 2'b00;
      r_res_sync  <= 2'b11;
      r_sclk_prev <= 1'b0;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_res_seen  <= 1'b0;
      r_ready     <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[0], spi_sclk};
      r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
      r_cs_sync   <= {r_cs_sync[0], spi_cs};
      r_dc_sync   <= {r_dc_sync[0], spi_dc};
      r_res_sync  <= {r_res_sync[0], spi_res};
      r_sclk_prev <= w_sclk;
      if (!w_res || w_cs) r_bitcnt <= '0;
      else if (w_rise) begin
        r_bitcnt <= (r_bitcnt == 4'd7) ? 4'd0 : r_bitcnt + 4'd1;
        r_shift  <= {r_shift[5:0], w_mosi};
      end
      if (w_flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        r_wptr  <= r_wptr + AW'(w_push);
        r_rptr  <= r_rptr + AW'(w_pop);
        r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
      // set events win over CTRL clears landing in the same cycle
      r_ovf      <= w_ovf_set | (r_ovf & ~(w_ctrl & bus.iomem_wdata[0]));
      r_res_seen <= ~w_res | (r_res_seen & ~(w_ctrl & bus.iomem_wdata[2]));
      r_ready    <= w_start;
      if (w_start)
        r_rdata <= w_wr ? 32'h0 :
                   (w_addr == 8'h00) ? (w_pop ? {1'b1, 22'b0, r_mem[r_rptr]} : 32'h0) :
                   (w_addr == 8'h04) ? w_status : 32'h0;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {w_dc, r_shift, w_mosi};
  end
endmodule

// File: tb/tb_spi_oled_rx.sv
// tb_spi_oled_rx: directed self-checking bench for spi_oled_rx at sclk = clk/8.
module tb_spi_oled_rx;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic spi_sclk = 1'b0, spi_mosi = 1'b0, spi_cs = 1'b1, spi_dc = 1'b0, spi_res = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] d;
  spi_oled_rx_if bus_if ();
  spi_oled_rx #(.FIFO_DEPTH(16)) dut (
    .clk(clk), .resetn(resetn), .bus(bus_if),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs(spi_cs), .spi_dc(spi_dc), .spi_res(spi_res)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic spi_bits(input logic [7:0] b, input logic dc, input int n);
    for (int i = 0; i < n; i++) begin
      spi_sclk = 1'b0;
      spi_mosi = b[7-i];
      spi_dc   = dc;
      wait_clk(4);
      spi_sclk = 1'b1;
      wait_clk(4);
    end
    spi_sclk = 1'b0;
    wait_clk(4);
  endtask
  task automatic bus(input logic [7:0] a, input logic [3:0] st, input logic [31:0] wd, output logic [31:0] rd);
    int k;
    @(negedge clk);
    bus_if.iomem_valid = 1'b1;
    bus_if.iomem_addr  = {24'h0, a};
    bus_if.iomem_wstrb = st;
    bus_if.iomem_wdata = wd;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus_if.iomem_ready && k < 8);
    chk("ready_seen", {31'b0, bus_if.iomem_ready}, 32'd1);
    rd = bus_if.iomem_rdata;
    bus_if.iomem_valid = 1'b0;
    bus_if.iomem_wstrb = 4'h0;
    @(negedge clk);
    chk("ready_single", {31'b0, bus_if.iomem_ready}, 32'd0);
    chk("rdata_hold", bus_if.iomem_rdata, rd);
  endtask
  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] r;
    bus(a, 4'h0, 32'h0, r);
    chk(tag, r, exp);
  endtask
  task automatic wr(input logic [7:0] a, input logic [31:0] wd);
    logic [31:0] r;
    bus(a, 4'hF, wd, r);
  endtask
  initial begin
    bus_if.iomem_valid = 1'b0;
    bus_if.iomem_wstrb = 4'h0;
    bus_if.iomem_addr  = 32'h0;
    bus_if.iomem_wdata = 32'h0;
    wait_clk(3);
    resetn = 1'b1;
    wait_clk(1);
    chk("rst_ready", {31'b0, bus_if.iomem_ready}, 32'd0);
    chk("rst_rdata", bus_if.iomem_rdata, 32'h0);
    rd_chk("rst_status", 8'h04, 32'h0000_0100);
    spi_cs = 1'b0;
    wait_clk(4);
    spi_bits(8'hA5, 1'b1, 8);
    rd_chk("a5_status", 8'h04, 32'h0000_0001);
    rd_chk("a5_rx", 8'h00, 32'h8000_01A5);
    rd_chk("a5_empty", 8'h04, 32'h0000_0100);
    rd_chk("empty_rx", 8'h00, 32'h0);
    spi_bits(8'hAF, 1'b0, 8);
    spi_bits(8'h81, 1'b0, 8);
    spi_bits(8'h3C, 1'b1, 8);
    rd_chk("seq_status", 8'h04, 32'h0000_0003);
    rd_chk("seq_rx0", 8'h00, 32'h8000_00AF);
    rd_chk("seq_rx1", 8'h00, 32'h8000_0081);
    rd_chk("seq_rx2", 8'h00, 32'h8000_013C);
    rd_chk("bad_addr", 8'h0C, 32'h0);
    wr(8'h00, 32'hFFFF_FFFF);
    rd_chk("ign_write", 8'h04, 32'h0000_0100);
    spi_bits(8'hF8, 1'b0, 5);
    rd_chk("part_bitcnt", 8'h04, 32'h0000_5100);
    spi_cs = 1'b1;
    wait_clk(6);
    rd_chk("cs_discard", 8'h04, 32'h0000_0100);
    spi_cs = 1'b0;
    wait_clk(4);
    spi_bits(8'h12, 1'b0, 8);
    rd_chk("after_cs_status", 8'h04, 32'h0000_0001);
    rd_chk("after_cs_rx", 8'h00, 32'h8000_0012);
    for (int i = 0; i < 17; i++) spi_bits(8'(i), 1'b0, 8);
    rd_chk("ovf_status", 8'h04, 32'h0000_0610);
    wr(8'h08, 32'h1);
    rd_chk("ovf_clr", 8'h04, 32'h0000_0210);
    rd_chk("full_rx0", 8'h00, 32'h8000_0000);
    spi_bits(8'h55, 1'b0, 8);
    rd_chk("refill", 8'h04, 32'h0000_0210);
    for (int i = 1; i < 16; i++) rd_chk("wrap_rx", 8'h00, 32'h8000_0000 | 32'(i));
    rd_chk("wrap_last", 8'h00, 32'h8000_0055);
    rd_chk("wrap_empty", 8'h04, 32'h0000_0100);
    spi_bits(8'h01, 1'b0, 8);
    spi_bits(8'h02, 1'b0, 8);
    wr(8'h08, 32'h2);
    rd_chk("ctrl_flush", 8'h04, 32'h0000_0100);
    spi_bits(8'h11, 1'b0, 8);
    spi_bits(8'h22, 1'b0, 8);
    spi_bits(8'h33, 1'b1, 8);
    rd_chk("res_pre", 8'h04, 32'h0000_0003);
    spi_res = 1'b0;
    wait_clk(5);
    spi_res = 1'b1;
    wait_clk(4);
    rd_chk("res_status", 8'h04, 32'h0000_0900);
    rd_chk("res_rx", 8'h00, 32'h0);
    wr(8'h08, 32'h4);
    rd_chk("res_clr", 8'h04, 32'h0000_0100);
    spi_bits(8'hF0, 1'b1, 4);
    rd_chk("mid_bitcnt", 8'h04, 32'h0000_4100);
    resetn = 1'b0;
    wait_clk(3);
    chk("rst2_ready", {31'b0, bus_if.iomem_ready}, 32'd0);
    chk("rst2_rdata", bus_if.iomem_rdata, 32'h0);
    resetn = 1'b1;
    wait_clk(4);
    rd_chk("rst2_status", 8'h04, 32'h0000_0100);
    spi_bits(8'hC3, 1'b1, 8);
    rd_chk("rst2_rx", 8'h00, 32'h8000_01C3);
    rd_chk("rst2_empty", 8'h04, 32'h0000_0100);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/spi_oled_rx.md
SPI_OLED_RX -- requirements
Module: spi_oled_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, received-byte buffer depth in entries (power of 2, 4..64).
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port iomem_valid  input  1  bus request.
REQ-005 SHALL have port iomem_ready  output  1  bus completion pulse.
REQ-006 SHALL have port iomem_wstrb  input  4  write strobes; nonzero means write, zero means read.
REQ-007 SHALL have port iomem_addr  input  32  byte address; only bits [7:0] decoded.
REQ-008 SHALL have port iomem_wdata  input  32  write data.
REQ-009 SHALL have port iomem_rdata  output  32  read data, valid when iomem_ready=1.
REQ-010 SHALL have ports spi_sclk, spi_mosi, spi_cs, spi_dc, spi_res  input  1 each  asynchronous SPI target lines; cs and res active-low.

Function
REQ-011 SHALL pass each SPI input through a 2-flop synchronizer before use; SPI timing is defined on the synchronized signals.
REQ-012 SHALL sample spi_mosi on each rising edge of synchronized sclk while synchronized cs=0, MSB first.
REQ-013 SHALL support sclk frequency up to clk/4; faster sclk is unsupported.
REQ-014 SHALL, on the 8th sampled bit, push {dc, byte} into the FIFO, with dc sampled at that same sclk edge, and reset the bit counter to 0.
REQ-015 SHALL, when cs=1, hold the bit counter at 0 and discard any partial byte.
REQ-016 SHALL, when res=0, flush the FIFO, clear the bit counter and set sticky flag RES_SEEN; no bytes pushed while res=0.
REQ-017 SHALL, on a push with the FIFO full and no same-cycle pop, discard the byte and set sticky flag OVF.
REQ-018 SHALL, on simultaneous push and pop, perform both; count unchanged; allowed when full.
REQ-019 SHALL decode registers: 0x00 RXDATA (read), 0x04 STATUS (read), 0x08 CTRL (write); other addresses read 0, writes ignored.
REQ-020 SHALL return RXDATA as bit31=valid, bit8=dc, bits[7:0]=data, others 0; a read when non-empty pops one entry; a read when empty returns 0 and changes no state.
REQ-021 SHALL return STATUS as bits[6:0]=entry count, bit8=empty, bit9=full, bit10=OVF, bit11=RES_SEEN, bits[15:12]=bit counter, others 0.
REQ-022 SHALL treat a CTRL write as: wdata bit0=1 clears OVF, bit1=1 flushes FIFO, bit2=1 clears RES_SEEN; a set event in the same cycle wins over clear.
REQ-023 SHALL assert iomem_ready for exactly one cycle, one cycle after iomem_valid is first seen high with iomem_ready low; iomem_ready SHALL be low in the following cycle.
REQ-024 SHALL perform exactly one pop per RXDATA read transaction, even if iomem_valid stays high across ready.
REQ-025 SHALL hold iomem_rdata stable from ready until the next transaction completes.
REQ-026 SHALL keep FIFO pointers wrapping modulo FIFO_DEPTH; count saturates at FIFO_DEPTH.

Reset
REQ-027 SHALL, on resetn=0 at a clk edge, set iomem_ready=0, iomem_rdata=0, FIFO empty, count=0, bit counter=0, OVF=0, RES_SEEN=0, synchronizers to idle (cs=1, res=1, sclk=0).
REQ-028 SHALL ignore SPI activity and bus requests while resetn=0; a byte in progress at reset is lost.

Verification
REQ-029 SHALL pass: cs=0, dc=1, send 0xA5 at clk/8 -> STATUS count=1; RXDATA read = 0x800001A5; then STATUS empty=1.
REQ-030 SHALL pass: dc=0 bytes 0xAF,0x81 then dc=1 0x3C -> reads 0x800000AF, 0x80000081, 0x8000013C in order.
REQ-031 SHALL pass: 5 bits sent, cs raised, then full byte 0x12 -> single entry 0x80000012.
REQ-032 SHALL pass: 17 bytes with FIFO_DEPTH=16, no reads -> count=16, OVF=1, 17th byte lost; CTRL write 0x1 -> OVF=0.
REQ-033 SHALL pass: 3 bytes queued, res pulsed low -> empty=1, RES_SEEN=1; RXDATA read returns 0x00000000.
REQ-034 SHALL pass: resetn low mid-byte -> all outputs 0, STATUS empty, next full byte received correctly.
